reg_file_mwp: RTL and testbench

REG_FILE_MWP -- requirements
Module: reg_file_mwp

---
 rtl/reg_file_pkg.sv | 25 ++
 rtl/rf_write_merge.sv | 38 +++
 rtl/reg_file_mwp.sv | 82 ++++++++
 tb/tb_reg_file_mwp.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and width helpers for the multi-write-port register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int N_WP_DEF   = 2;
  localparam int N_RP_DEF   = 2;
  localparam int BYPASS_DEF = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // A one-entry-wide address still needs one bit.
  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/rf_write_merge.sv
// Next-value computation for one entry: byte-merges all write ports, higher
// port index wins per byte lane; clear overrides everything.
module rf_write_merge import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW     = 2,
  parameter int N_WP   = N_WP_DEF,
  parameter int IDX    = 0
) (
  input  logic [DATA_W-1:0]             cur_in,
  input  logic                          clr_in,
  input  logic [N_WP-1:0]               wen_in,
  input  logic [N_WP*AW-1:0]            waddr_in,
  input  logic [N_WP*DATA_W-1:0]        wdata_in,
  input  logic [N_WP*be_w(DATA_W)-1:0]  wbe_in,
  output logic [DATA_W-1:0]             nxt_out,
  output logic                          hit_out
);
  localparam int BE_W = be_w(DATA_W);

  always_comb begin
    nxt_out = cur_in;
    hit_out = 1'b0;
    for (int p = 0; p < N_WP; p++) begin
      if (wen_in[p] && (waddr_in[p*AW +: AW] == AW'(IDX))) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wbe_in[p*BE_W + b]) begin
            nxt_out[b*8 +: 8] = wdata_in[p*DATA_W + b*8 +: 8];
            hit_out           = 1'b1;
          end
        end
      end
    end
    if (clr_in) begin
      nxt_out = '0;
      hit_out = 1'b0;
    end
  end
endmodule

// File: rtl/reg_file_mwp.sv
// Multi-write-port register file with byte enables, synchronous clear,
// registered read ports and optional write-to-read bypass.
module reg_file_mwp import reg_file_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int N_WP   = N_WP_DEF,
  parameter int N_RP   = N_RP_DEF,
  parameter int BYPASS = BYPASS_DEF
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N_WP-1:0]                       wen_in,
  input  logic [N_WP*addr_w(DEPTH)-1:0]         waddr_in,
  input  logic [N_WP*DATA_W-1:0]                wdata_in,
  input  logic [N_WP*be_w(DATA_W)-1:0]          wbe_in,
  input  logic                                  clr_in,
  input  logic [N_RP-1:0]                       ren_in,
  input  logic [N_RP*addr_w(DEPTH)-1:0]         raddr_in,
  output logic [N_RP*DATA_W-1:0]                rdata_out,
  output logic [N_RP-1:0]                       rvalid_out,
  output logic [DEPTH*DATA_W-1:0]               a_out,
  output logic [DEPTH-1:0]                      vld_out
);
  localparam int AW = addr_w(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             vld_q, vld_d, hit;
  logic [N_RP-1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic [N_RP-1:0]              rvalid_q, rvalid_d;

  // Out-of-range write addresses match no instance, so they drop naturally.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rf_write_merge #(
      .DATA_W(DATA_W), .AW(AW), .N_WP(N_WP), .IDX(i)
    ) u_merge (
      .cur_in  (mem_q[i]),
      .clr_in  (clr_in),
      .wen_in  (wen_in),
      .waddr_in(waddr_in),
      .wdata_in(wdata_in),
      .wbe_in  (wbe_in),
      .nxt_out (mem_d[i]),
      .hit_out (hit[i])
    );
    assign a_out[DATA_W*(DEPTH-1-i) +: DATA_W] = mem_q[i];
  end

  always_comb begin
    vld_d = clr_in ? '0 : (vld_q | hit);
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ren_in;
    for (int r = 0; r < N_RP; r++) begin
      if (ren_in[r]) begin
        rdata_d[r] = '0;
        for (int i = 0; i < DEPTH; i++)
          if (raddr_in[r*AW +: AW] == AW'(i))
            rdata_d[r] = (BYPASS != 0) ? mem_d[i] : mem_q[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      vld_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign vld_out    = vld_q;
  assign rdata_out  = rdata_q;
  assign rvalid_out = rvalid_q;
endmodule

// File: tb/tb_reg_file_mwp.sv
// Directed vectors driven into three builds in parallel: default (bypass),
// BYPASS=0, and DEPTH=3 (same address width, one missing entry).
module tb_reg_file_mwp;
  logic        clock, reset, clr_in;
  logic [1:0]  wen_in, ren_in;
  logic [3:0]  waddr_in, raddr_in, wbe_in;
  logic [31:0] wdata_in;

  logic [31:0] rd0, rd1, rd2;
  logic [1:0]  rv0, rv1, rv2;
  logic [63:0] a0, a1;
  logic [47:0] a2;
  logic [3:0]  v0, v1;
  logic [2:0]  v2;

  int total = 0;
  int bad   = 0;

  reg_file_mwp #(.BYPASS(1)) u_byp (
    .clock(clock), .reset(reset), .wen_in(wen_in), .waddr_in(waddr_in),
    .wdata_in(wdata_in), .wbe_in(wbe_in), .clr_in(clr_in), .ren_in(ren_in),
    .raddr_in(raddr_in), .rdata_out(rd0), .rvalid_out(rv0), .a_out(a0), .vld_out(v0));

  reg_file_mwp #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .wen_in(wen_in), .waddr_in(waddr_in),
    .wdata_in(wdata_in), .wbe_in(wbe_in), .clr_in(clr_in), .ren_in(ren_in),
    .raddr_in(raddr_in), .rdata_out(rd1), .rvalid_out(rv1), .a_out(a1), .vld_out(v1));

  reg_file_mwp #(.DEPTH(3)) u_d3 (
    .clock(clock), .reset(reset), .wen_in(wen_in), .waddr_in(waddr_in),
    .wdata_in(wdata_in), .wbe_in(wbe_in), .clr_in(clr_in), .ren_in(ren_in),
    .raddr_in(raddr_in), .rdata_out(rd2), .rvalid_out(rv2), .a_out(a2), .vld_out(v2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        clr;
    logic [1:0]  ren;
    logic [3:0]  raddr;
    logic [63:0] exp_a;
    logic [3:0]  exp_vld;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd_nb;
    logic [47:0] exp_a3;
    logic [2:0]  exp_vld3;
    logic [31:0] exp_rd3;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wen_in = '0; waddr_in = '0; wdata_in = '0; wbe_in = '0;
    clr_in = 1'b0; ren_in = '0; raddr_in = '0;
  endtask

  initial begin
    // {p1,p0} packing for every two-port field; a_out is {e0,e1,e2,e3}
    vt[0] = '{2'b01, {2'd0,2'd2}, 32'h0000_BEEF, 4'b0011, 1'b0, 2'b00, 4'h0,
              64'h0000_0000_BEEF_0000, 4'b0100, 32'h0, 2'b00, 32'h0,
              48'h0000_0000_BEEF, 3'b100, 32'h0};
    vt[1] = '{2'b11, {2'd1,2'd1}, 32'h2222_1111, 4'b0111, 1'b0, 2'b11, {2'd1,2'd2},
              64'h0000_1122_BEEF_0000, 4'b0110, 32'h1122_BEEF, 2'b11, 32'h0000_BEEF,
              48'h0000_1122_BEEF, 3'b110, 32'h1122_BEEF};
    vt[2] = '{2'b01, {2'd0,2'd3}, 32'h0000_A5A5, 4'b0011, 1'b0, 2'b01, {2'd0,2'd3},
              64'h0000_1122_BEEF_A5A5, 4'b1110, 32'h1122_A5A5, 2'b01, 32'h0,
              48'h0000_1122_BEEF, 3'b110, 32'h1122_0000};
    vt[3] = '{2'b01, {2'd0,2'd0}, 32'h0000_1234, 4'b0000, 1'b0, 2'b00, 4'h0,
              64'h0000_1122_BEEF_A5A5, 4'b1110, 32'h1122_A5A5, 2'b00, 32'h0,
              48'h0000_1122_BEEF, 3'b110, 32'h1122_0000};
    vt[4] = '{2'b01, {2'd0,2'd0}, 32'h0000_ABCD, 4'b0010, 1'b0, 2'b10, {2'd0,2'd0},
              64'hAB00_1122_BEEF_A5A5, 4'b1111, 32'hAB00_A5A5, 2'b10, 32'h0,
              48'hAB00_1122_BEEF, 3'b111, 32'hAB00_0000};
    vt[5] = '{2'b01, {2'd0,2'd0}, 32'h0000_FFFF, 4'b0011, 1'b1, 2'b01, {2'd0,2'd0},
              64'h0, 4'b0000, 32'hAB00_0000, 2'b01, 32'h0000_AB00,
              48'h0, 3'b000, 32'hAB00_0000};
    vt[6] = '{2'b11, {2'd2,2'd2}, 32'h7777_6666, 4'b1111, 1'b0, 2'b00, 4'h0,
              64'h0000_0000_7777_0000, 4'b0100, 32'hAB00_0000, 2'b00, 32'h0000_AB00,
              48'h0000_0000_7777, 3'b100, 32'hAB00_0000};

    idle();
    reset = 1'b1;
    #1;
    chk("reset a_out", a0, 64'h0);
    chk("reset vld", {60'h0, v0}, 64'h0);
    chk("reset rdata", {32'h0, rd0}, 64'h0);
    chk("reset rvalid", {62'h0, rv0}, 64'h0);

    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      wen_in = vt[k].wen; waddr_in = vt[k].waddr; wdata_in = vt[k].wdata;
      wbe_in = vt[k].wbe; clr_in = vt[k].clr; ren_in = vt[k].ren; raddr_in = vt[k].raddr;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d a_out", k), a0, vt[k].exp_a);
      chk($sformatf("v%0d vld", k), {60'h0, v0}, {60'h0, vt[k].exp_vld});
      chk($sformatf("v%0d rdata", k), {32'h0, rd0}, {32'h0, vt[k].exp_rd});
      chk($sformatf("v%0d rvalid", k), {62'h0, rv0}, {62'h0, vt[k].exp_rv});
      chk($sformatf("v%0d nb a_out", k), a1, vt[k].exp_a);
      chk($sformatf("v%0d nb rdata", k), {32'h0, rd1}, {32'h0, vt[k].exp_rd_nb});
      chk($sformatf("v%0d nb rvalid", k), {62'h0, rv1}, {62'h0, vt[k].exp_rv});
      chk($sformatf("v%0d d3 a_out", k), {16'h0, a2}, {16'h0, vt[k].exp_a3});
      chk($sformatf("v%0d d3 vld", k), {61'h0, v2}, {61'h0, vt[k].exp_vld3});
      chk($sformatf("v%0d d3 rdata", k), {32'h0, rd2}, {32'h0, vt[k].exp_rd3});
      chk($sformatf("v%0d d3 rvalid", k), {62'h0, rv2}, {62'h0, vt[k].exp_rv});
    end

    // Load a read result, then hit reset between edges with a read pending.
    @(negedge clock);
    idle();
    wen_in = 2'b01; waddr_in = {2'd0, 2'd1}; wdata_in = 32'h0000_5A5A; wbe_in = 4'b0011;
    ren_in = 2'b01; raddr_in = {2'd0, 2'd1};
    @(posedge clock);
    #1;
    chk("pre-reset rdata", {32'h0, rd0}, {32'h0, 32'hAB00_5A5A});
    chk("pre-reset rvalid", {62'h0, rv0}, 64'h1);
    @(negedge clock);
    idle();
    ren_in = 2'b01; raddr_in = {2'd0, 2'd1};
    #2 reset = 1'b1;
    #1;
    chk("async reset rdata", {32'h0, rd0}, 64'h0);
    chk("async reset rvalid", {62'h0, rv0}, 64'h0);
    chk("async reset a_out", a0, 64'h0);
    chk("async reset vld", {60'h0, v0}, 64'h0);
    #1;
    idle();
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post-reset rdata", {32'h0, rd0}, 64'h0);
    chk("post-reset rvalid", {62'h0, rv0}, 64'h0);
    chk("post-reset a_out", a0, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
